// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and counter width helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  // Width of a counter that must reach clks_per_bit-1 (never narrower than 1 bit).
  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  // Width of a counter that must reach data_width-1 (never narrower than 1 bit).
  function automatic int bit_cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider shared by the UART transmitter and receiver. The counter runs
// 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W    = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter: held at zero while cleared so a new bit starts aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmit engine on the read side of the TX FIFO: pops one word per
// frame and shifts it out as start bit, LSB-first data, optional parity and
// stop bit(s). The line output comes straight from a flop.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_ren,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int               BIT_W     = bit_cnt_width(DATA_WIDTH);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Parity of a data word; odd selects the inverted (odd) sense.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  tx_state_t             state_r, next_state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_next_s;
  logic                  parity_r, parity_next_s;
  logic                  tx_r, tx_next_s;
  logic                  start_req_s;
  logic                  baud_clear_s, baud_tick_s;

  assign start_req_s = tx_en & ~fifo_empty;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear_s),
    .tick (baud_tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; bit and stop-bit boundaries come from the baud tick.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_req_s) next_state_s = FETCH;
        else             next_state_s = IDLE;
      end
      FETCH: next_state_s = START;
      START: begin
        if (baud_tick_s) next_state_s = DATA;
        else             next_state_s = START;
      end
      DATA: begin
        if (baud_tick_s && (bit_cnt_r == DATA_LAST)) begin
          if (PARITY_EN != 0) next_state_s = PARITY;
          else                next_state_s = STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (baud_tick_s) next_state_s = STOP;
        else             next_state_s = PARITY;
      end
      STOP: begin
        if (baud_tick_s && (bit_cnt_r == STOP_LAST)) next_state_s = IDLE;
        else                                         next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: pop strobe (gated by reset so nothing pops while held), busy, done, baud clear.
  always_comb begin
    fifo_ren     = 1'b0;
    tx_done      = 1'b0;
    baud_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        fifo_ren     = rst & start_req_s;
        baud_clear_s = 1'b1;
      end
      FETCH: baud_clear_s = 1'b1;
      STOP: begin
        if (baud_tick_s && (bit_cnt_r == STOP_LAST)) tx_done = 1'b1;
        else                                         tx_done = 1'b0;
      end
      default: begin
        fifo_ren     = 1'b0;
        tx_done      = 1'b0;
        baud_clear_s = 1'b0;
      end
    endcase
    busy = (state_r != IDLE) | fifo_ren;
  end

  // Datapath next values: load in FETCH, shift on data bit boundaries, count bits and stop bits.
  always_comb begin
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    parity_next_s  = parity_r;
    case (state_r)
      FETCH: begin
        shift_next_s   = fifo_dout;
        parity_next_s  = calc_parity(fifo_dout, (PARITY_ODD != 0));
        bit_cnt_next_s = {BIT_W{1'b0}};
      end
      DATA: begin
        if (baud_tick_s) begin
          shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          if (bit_cnt_r == DATA_LAST) bit_cnt_next_s = {BIT_W{1'b0}};
          else                        bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
        end else begin
          shift_next_s = shift_r;
        end
      end
      STOP: begin
        if (baud_tick_s && (bit_cnt_r != STOP_LAST)) bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
        else if (baud_tick_s)                        bit_cnt_next_s = {BIT_W{1'b0}};
        else                                         bit_cnt_next_s = bit_cnt_r;
      end
      default: begin
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        parity_next_s  = parity_r;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the state being entered.
  always_comb begin
    tx_next_s = 1'b1;
    case (next_state_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      PARITY:  tx_next_s = parity_next_s;
      default: tx_next_s = 1'b1;
    endcase
  end

  // Datapath registers, including the glitch-free line flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      parity_r  <= 1'b0;
      tx_r      <= 1'b1;
    end else begin
      shift_r   <= shift_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      parity_r  <= parity_next_s;
      tx_r      <= tx_next_s;
    end
  end

  assign tx = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench for uart_tx_fifo_reader. Three DUT lanes at CLKS_PER_BIT=4:
// lane 0 no parity / 1 stop, lane 1 even parity / 2 stops, lane 2 odd parity / 1 stop.
`timescale 1ns/1ps
module tb_uart_tx_fifo_reader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] tx_en = 3'b000;
  logic [2:0] fifo_empty, fifo_ren, tx, busy, tx_done;
  logic [7:0] fifo_dout [3] = '{8'h00, 8'h00, 8'h00};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // FIFO model per lane
  logic [7:0] fifo_mem [3][16];
  int         wr_ptr [3];
  int         rd_ptr [3];
  logic [2:0] ren_seen = 3'b000;
  logic [2:0] pend_q;

  // Scoreboard entries: {back_to_back, parity_bit, data}
  logic [9:0] exp_mem [3][16];
  int         exp_wr [3];
  int         exp_rd [3];

  // Monitor state
  int         pops [3];
  int         frames [3];
  int         ren_cyc [3];
  int         done_cyc [3];
  int         k_cnt [3];
  logic [2:0] active = 3'b000;
  logic [2:0] bad = 3'b000;
  logic [9:0] cur [3];
  int         fl_m;
  logic       eb_m, ed_m;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_empty
    assign fifo_empty[g] = (rd_ptr[g] == wr_ptr[g]);
  end

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
    .fifo_ren(fifo_ren[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
    .fifo_ren(fifo_ren[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]), .fifo_dout(fifo_dout[2]),
    .fifo_ren(fifo_ren[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  function automatic int lane_pe(input int l);
    return (l == 0) ? 0 : 1;
  endfunction

  function automatic int lane_sb(input int l);
    return (l == 1) ? 2 : 1;
  endfunction

  // Expected line level k cycles after the start bit begins.
  function automatic logic exp_bit(input int l, input int k, input logic [9:0] e);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return e[slot-1];
    if ((lane_pe(l) == 1) && (slot == 9)) return e[8];
    return 1'b1;
  endfunction

  // FIFO read port model: data appears just after the edge that follows a pop.
  always @(posedge clk) begin
    pend_q = ren_seen;
    #1;
    for (int l = 0; l < 3; l++) begin
      if (pend_q[l]) begin
        fifo_dout[l] = fifo_mem[l][rd_ptr[l] % 16];
        rd_ptr[l] = rd_ptr[l] + 1;
      end
    end
  end

  // Monitor: frame decoder and scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    ren_seen = fifo_ren & {3{rst}};
    for (int l = 0; l < 3; l++) begin
      if (!rst) begin
        active[l] = 1'b0;
      end else begin
        if (fifo_ren[l]) begin
          pops[l] = pops[l] + 1;
          ren_cyc[l] = cyc;
          if (fifo_empty[l] || active[l]) begin
            miscompares++;
            $display("FAIL ren_guard lane%0d: empty=%b active=%b, required 0 and 0", l, fifo_empty[l], active[l]);
          end
        end
        if (!active[l] && (tx[l] == 1'b0)) begin
          active[l] = 1'b1;
          k_cnt[l] = 0;
          bad[l] = 1'b0;
          if (exp_rd[l] == exp_wr[l]) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame lane%0d: tx went low at cycle %0d, required idle high", l, cyc);
            cur[l] = 10'h000;
            bad[l] = 1'b1;
          end else begin
            cur[l] = exp_mem[l][exp_rd[l] % 16];
            exp_rd[l] = exp_rd[l] + 1;
            vectors++;
            if (cyc - ren_cyc[l] != 2) begin
              miscompares++;
              $display("FAIL latency lane%0d: pop-to-start %0d cycles, required 2", l, cyc - ren_cyc[l]);
            end
            if (cur[l][9]) begin
              vectors++;
              if (cyc - done_cyc[l] - 1 != 2) begin
                miscompares++;
                $display("FAIL gap lane%0d: %0d idle cycles, required 2", l, cyc - done_cyc[l] - 1);
              end
            end
          end
        end else if (!active[l] && tx_done[l]) begin
          miscompares++;
          $display("FAIL spurious_done lane%0d: tx_done=1 outside a frame, required 0", l);
        end
        if (active[l]) begin
          fl_m = (1 + 8 + lane_pe(l) + lane_sb(l)) * CPB;
          eb_m = exp_bit(l, k_cnt[l], cur[l]);
          ed_m = (k_cnt[l] == fl_m - 1);
          if ((tx[l] !== eb_m) || (tx_done[l] !== ed_m) || (busy[l] !== 1'b1)) begin
            if (!bad[l]) begin
              $display("FAIL frame lane%0d data %h k=%0d: tx=%b done=%b busy=%b, required tx=%b done=%b busy=1",
                       l, cur[l][7:0], k_cnt[l], tx[l], tx_done[l], busy[l], eb_m, ed_m);
            end
            bad[l] = 1'b1;
          end
          k_cnt[l] = k_cnt[l] + 1;
          if (k_cnt[l] == fl_m) begin
            vectors++;
            if (bad[l]) miscompares++;
            active[l] = 1'b0;
            done_cyc[l] = cyc;
            frames[l] = frames[l] + 1;
          end
        end
      end
    end
  end

  task automatic push(input int l, input logic [7:0] d, input logic par, input logic b2b);
    fifo_mem[l][wr_ptr[l] % 16] = d;
    wr_ptr[l] = wr_ptr[l] + 1;
    exp_mem[l][exp_wr[l] % 16] = {b2b, par, d};
    exp_wr[l] = exp_wr[l] + 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_bits(input string name, input logic [2:0] got, input logic [2:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_frames(input int l, input int target, input int budget);
    int t;
    t = 0;
    while ((frames[l] < target) && (t < budget)) begin
      step(1);
      t++;
    end
    check_int("frame_count", frames[l], target);
  endtask

  initial begin
    step(3);
    check_bits("rst_tx", tx, 3'b111);
    check_bits("rst_busy", busy, 3'b000);
    check_bits("rst_done", tx_done, 3'b000);
    // Word waiting and tx_en high while reset is held: still no pop
    push(0, 8'hA5, 1'b0, 1'b0);
    tx_en[0] = 1'b1;
    step(1);
    check_bits("rst_ren", fifo_ren, 3'b000);
    check_bits("rst_busy_req", busy, 3'b000);
    // Test 1: single 0xA5 frame on lane 0
    rst = 1'b1;
    wait_frames(0, 1, 100);
    check_int("pops_single", pops[0], 1);
    // Test 2: back-to-back 0x00 then 0xFF
    push(0, 8'h00, 1'b0, 1'b0);
    push(0, 8'hFF, 1'b0, 1'b1);
    wait_frames(0, 3, 300);
    check_int("pops_b2b", pops[0], 3);
    // Tests 3 and 6: parity lanes (lane 1 even + 2 stops, lane 2 odd)
    push(1, 8'h07, 1'b1, 1'b0);
    push(1, 8'hFF, 1'b0, 1'b1);
    push(2, 8'h07, 1'b0, 1'b0);
    push(2, 8'h00, 1'b1, 1'b1);
    tx_en[2:1] = 2'b11;
    wait_frames(1, 2, 300);
    wait_frames(2, 2, 300);
    // Test 4: tx_en low with a non-empty FIFO
    tx_en = 3'b000;
    push(0, 8'h3C, 1'b0, 1'b0);
    step(30);
    check_int("pops_disabled", pops[0], 3);
    check_bits("tx_disabled", tx, 3'b111);
    // Drop tx_en mid-frame: frame completes, the waiting 0x81 is not popped
    push(0, 8'h81, 1'b0, 1'b0);
    tx_en[0] = 1'b1;
    step(10);
    tx_en[0] = 1'b0;
    wait_frames(0, 4, 200);
    step(20);
    check_int("pops_after_drop", pops[0], 4);
    // Test 5: reset during data bit 3 of 0x81 (bit 3 = 0)
    tx_en[0] = 1'b1;
    step(19);
    check_bits("pre_rst_tx", tx, 3'b110);
    rst = 1'b0;
    #1;
    check_bits("mid_rst_tx", tx, 3'b111);
    check_bits("mid_rst_busy", busy, 3'b000);
    step(3);
    rst = 1'b1;
    step(30);
    check_int("pops_no_repop", pops[0], 5);
    check_bits("tx_after_rst", tx, 3'b111);
    push(0, 8'h5A, 1'b0, 1'b0);
    wait_frames(0, 5, 200);
    check_int("pops_final", pops[0], 6);
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
